pir_stim_seq: RTL

Parametrised, synthesizable stimulus-and-check sequencer for the motion-detection alarm core. It drives N_CH PIR sensor lines and the `stop_alarm` acknowledge according to a fixed per-channel script. It waits for the core's alarm response and records any channel whose alarm never arrives. It sits beside the alarm core in simulation and on-board self-test builds, replacing hand-written per-sensor stimulus with a reusable, channel-count-agnostic block.

---
 rtl/pir_stim_seq.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/pir_stim_seq.sv
// -----------------------------------------------------------------------------
// pir_stim_seq
//
// Stimulus-and-check sequencer for the motion-detection alarm core. For each
// channel step it waits a delay, pulses one PIR sensor line, waits for the
// core's alarm and acknowledges it with a stop_alarm pulse. A channel whose
// alarm does not arrive within the timeout is flagged in miss_mask and its
// acknowledge is skipped.
//
// Ports:
//   clk        in   1     system clock, rising edge
//   rst_n      in   1     synchronous active-low reset
//   start      in   1     begin a run (honoured only in IDLE or DONE)
//   alarm_in   in   1     alarm level from the core (latched until ack)
//   pir_sensor out  N_CH  one-hot sensor stimulus
//   stop_alarm out  1     alarm acknowledge pulse
//   busy       out  1     run in progress
//   done       out  1     run complete, held until the next start
//   miss_mask  out  N_CH  sticky per-channel missed-alarm flags
//
// Optional feature macro: PIR_STIM_LFSR_EN
//   Defined   : channel order from a 16-bit Fibonacci LFSR (taps 16,14,13,11,
//               seed 16'hACE1), delay lengthened by lfsr[3:0].
//   Undefined : sequential channels and fixed delay; no LFSR logic exists.
// -----------------------------------------------------------------------------
module pir_stim_seq #(
    parameter int N_CH          = 3,
    parameter int START_DELAY   = 5,
    parameter int PULSE_LEN     = 2,
    parameter int ALARM_TIMEOUT = 8,
    parameter int ACK_DELAY     = 3,
    parameter int ACK_LEN       = 2,
    parameter int ROUNDS        = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            alarm_in,
    output logic [N_CH-1:0] pir_sensor,
    output logic            stop_alarm,
    output logic            busy,
    output logic            done,
    output logic [N_CH-1:0] miss_mask
);

`ifdef PIR_STIM_LFSR_EN
    localparam int DELAY_MAX = START_DELAY + 15;
`else
    localparam int DELAY_MAX = START_DELAY;
`endif

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_P = max2(max2(max2(DELAY_MAX, PULSE_LEN),
                                     max2(ALARM_TIMEOUT, ACK_DELAY)), ACK_LEN);
    localparam int CNT_W = $clog2(MAX_P + 1);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int RND_W = $clog2(ROUNDS + 1);

    typedef enum logic [2:0] {
        IDLE, DELAY, PULSE, WAIT_ALARM, ACK_GAP, ACK, NEXT, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   step_q, step_d;
    logic [RND_W-1:0]  round_q, round_d;
    logic [N_CH-1:0]   pir_q, pir_d;
    logic              stop_q, stop_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [N_CH-1:0]   miss_q, miss_d;

    logic [CH_W-1:0]   ch;          // channel served by the current step
    logic [N_CH-1:0]   ch_onehot;
    logic [CNT_W-1:0]  delay_last;  // final count value of DELAY

`ifdef PIR_STIM_LFSR_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign ch         = CH_W'(lfsr_q % 16'(N_CH));
    assign delay_last = CNT_W'(START_DELAY - 1) + CNT_W'(lfsr_q[3:0]);
`else
    assign ch         = step_q;
    assign delay_last = CNT_W'(START_DELAY - 1);
`endif

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_onehot
            assign ch_onehot[gi] = (ch == CH_W'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        round_d = round_q;
        miss_d  = miss_q;
`ifdef PIR_STIM_LFSR_EN
        lfsr_d  = lfsr_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DELAY;
                    cnt_d   = '0;
                    step_d  = '0;
                    round_d = '0;
                    miss_d  = '0;
`ifdef PIR_STIM_LFSR_EN
                    lfsr_d  = LFSR_SEED;
`endif
                end
            end
            DELAY: begin
                if (cnt_q == delay_last) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt_q == CNT_W'(PULSE_LEN - 1)) begin
                    state_d = WAIT_ALARM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_ALARM: begin
                if (alarm_in) begin
                    state_d = ACK_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(ALARM_TIMEOUT - 1)) begin
                    // No alarm: flag the channel and skip the acknowledge.
                    state_d = NEXT;
                    cnt_d   = '0;
                    miss_d  = miss_q | ch_onehot;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK_GAP: begin
                if (cnt_q == CNT_W'(ACK_DELAY - 1)) begin
                    state_d = ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK: begin
                if (cnt_q == CNT_W'(ACK_LEN - 1)) begin
                    state_d = NEXT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            NEXT: begin
                cnt_d = '0;
`ifdef PIR_STIM_LFSR_EN
                lfsr_d = {lfsr_q[14:0], lfsr_fb};
`endif
                if (step_q == CH_W'(N_CH - 1)) begin
                    step_d  = '0;
                    round_d = round_q + RND_W'(1);
                    state_d = (round_q == RND_W'(ROUNDS - 1)) ? DONE : DELAY;
                end else begin
                    step_d  = step_q + CH_W'(1);
                    state_d = DELAY;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        pir_d  = (state_d == PULSE) ? ch_onehot : '0;
        stop_d = (state_d == ACK);
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            round_q <= '0;
            pir_q   <= '0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            miss_q  <= '0;
`ifdef PIR_STIM_LFSR_EN
            lfsr_q  <= LFSR_SEED;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            round_q <= round_d;
            pir_q   <= pir_d;
            stop_q  <= stop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            miss_q  <= miss_d;
`ifdef PIR_STIM_LFSR_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    assign pir_sensor = pir_q;
    assign stop_alarm = stop_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign miss_mask  = miss_q;

endmodule
